// File: rtl/univ_shift_reg_pkg.sv
// rtl/univ_shift_reg_pkg.sv - mode constants and FSM encoding for univ_shift_reg
package univ_shift_reg_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

endpackage

// File: rtl/univ_shift_reg_ctrl.sv
// rtl/univ_shift_reg_ctrl.sv - sequencing FSM: issues load/shift enables, tracks count, busy and done
module univ_shift_reg_ctrl
   import univ_shift_reg_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int LSB_FIRST = 1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] i_mode,
   input  logic       i_start,
   output logic       o_load,
   output logic       o_shr,
   output logic       o_shl,
   output logic       o_busy,
   output logic       o_done
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t          r_state;
   state_t          w_next_state;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_next_count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_next_state;
         r_count <= w_next_count;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_next_count = r_count;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_next_state = ST_SHIFT;
               w_next_count = '0;
            end
         end
         ST_SHIFT: begin
            // The edge leaving the last count still shifts; it also returns to IDLE.
            if (r_count == LAST) begin
               w_next_state = ST_IDLE;
               w_next_count = '0;
            end else begin
               w_next_count = r_count + 1'b1;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      o_load = 1'b0;
      o_shr  = 1'b0;
      o_shl  = 1'b0;
      o_busy = (r_state == ST_SHIFT);
      o_done = (r_state == ST_SHIFT) && (r_count == LAST);
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               o_load = 1'b1;
            end else begin
               case (i_mode)
                  MODE_SHR:  o_shr  = 1'b1;
                  MODE_SHL:  o_shl  = 1'b1;
                  MODE_LOAD: o_load = 1'b1;
                  default:   o_load = 1'b0;
               endcase
            end
         end
         ST_SHIFT: begin
            if (LSB_FIRST != 0) o_shr = 1'b1;
            else                o_shl = 1'b1;
         end
         default: o_load = 1'b0;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal shift register with auto-serialise; optional rotate via UNIV_SHIFT_REG_ROTATE_EN
module univ_shift_reg
   import univ_shift_reg_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int LSB_FIRST = 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       mode,
   input  logic             sin_msb,
   input  logic             sin_lsb,
   input  logic [WIDTH-1:0] pdi,
   input  logic             start,
   input  logic             rot,
   output logic [WIDTH-1:0] pdo,
   output logic             sout_lsb,
   output logic             sout_msb,
   output logic             busy,
   output logic             done
);

   logic [WIDTH-1:0] r_q;
   logic             w_load;
   logic             w_shr;
   logic             w_shl;
   logic             w_fill_msb;
   logic             w_fill_lsb;

   univ_shift_reg_ctrl #(
      .WIDTH     (WIDTH),
      .LSB_FIRST (LSB_FIRST)
   ) u_ctrl (
      .clk     (clk),
      .reset_n (reset_n),
      .i_mode  (mode),
      .i_start (start),
      .o_load  (w_load),
      .o_shr   (w_shr),
      .o_shl   (w_shl),
      .o_busy  (busy),
      .o_done  (done)
   );

`ifdef UNIV_SHIFT_REG_ROTATE_EN
   // Rotation refills each end from the bit leaving the opposite end.
   assign w_fill_msb = rot ? r_q[0]       : sin_msb;
   assign w_fill_lsb = rot ? r_q[WIDTH-1] : sin_lsb;
`else
   logic w_unused_rot;
   assign w_unused_rot = rot;
   assign w_fill_msb   = sin_msb;
   assign w_fill_lsb   = sin_lsb;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_q <= '0;
      end else if (w_load) begin
         r_q <= pdi;
      end else if (w_shr) begin
         r_q <= {w_fill_msb, r_q[WIDTH-1:1]};
      end else if (w_shl) begin
         r_q <= {r_q[WIDTH-2:0], w_fill_lsb};
      end
   end

   assign pdo      = r_q;
   assign sout_lsb = r_q[0];
   assign sout_msb = r_q[WIDTH-1];

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - self-checking bench for univ_shift_reg against a behavioural model
module tb_univ_shift_reg;

   localparam int W   = 4;
   localparam int LSB = 1;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic [1:0]   mode = 2'b11;
   logic         sin_msb = 1'b0;
   logic         sin_lsb = 1'b0;
   logic [W-1:0] pdi = '1;
   logic         start = 1'b0;
   logic         rot = 1'b0;
   logic [W-1:0] pdo;
   logic         sout_lsb, sout_msb, busy, done;

   int n_checks = 0;
   int n_fail   = 0;
   int n_done   = 0;

   univ_shift_reg #(.WIDTH(W), .LSB_FIRST(LSB)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .mode     (mode),
      .sin_msb  (sin_msb),
      .sin_lsb  (sin_lsb),
      .pdi      (pdi),
      .start    (start),
      .rot      (rot),
      .pdo      (pdo),
      .sout_lsb (sout_lsb),
      .sout_msb (sout_msb),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Model: register value plus number of busy cycles still to run.
   logic [W-1:0] m_q = '0;
   int           m_left = 0;

   function automatic logic rotating();
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      return rot;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [W-1:0] m_right(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v >> 1;
      r[W-1] = rotating() ? v[0] : sin_msb;
      return r;
   endfunction

   function automatic logic [W-1:0] m_left_sh(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v << 1;
      r[0] = rotating() ? v[W-1] : sin_lsb;
      return r;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_q    <= '0;
         m_left <= 0;
      end else if (m_left > 0) begin
         m_q    <= (LSB != 0) ? m_right(m_q) : m_left_sh(m_q);
         m_left <= m_left - 1;
      end else if (start) begin
         m_q    <= pdi;
         m_left <= W;
      end else begin
         case (mode)
            2'b01:   m_q <= m_right(m_q);
            2'b10:   m_q <= m_left_sh(m_q);
            2'b11:   m_q <= pdi;
            default: m_q <= m_q;
         endcase
      end
   end

   always begin
      @(posedge clk);
      #2;
      chk("model_pdo", pdo, m_q);
      chk("model_sout_lsb", W'(sout_lsb), W'(m_q[0]));
      chk("model_sout_msb", W'(sout_msb), W'(m_q[W-1]));
      chk("model_busy", W'(busy), W'(m_left > 0));
      chk("model_done", W'(done), W'(m_left == 1));
   end

   always @(posedge done) n_done++;

   logic [W-1:0] bits, bz, dn;
   int           d0;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_pdo", pdo, 4'b0000);
      chk("reset_busy", W'(busy), '0);
      chk("reset_done", W'(done), '0);
      mode    = 2'b00;
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("hold_after_reset", pdo, 4'b0000);

      mode = 2'b11; pdi = 4'b1011;
      @(negedge clk);
      mode = 2'b00;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_1011", pdo, 4'b1011);
      end

      mode = 2'b01; sin_msb = 1'b0;
      @(negedge clk);
      chk("shift_right", pdo, 4'b0101);
      mode = 2'b10; sin_lsb = 1'b1;
      @(negedge clk);
      chk("shift_left", pdo, 4'b1011);
      mode = 2'b00; sin_lsb = 1'b0;

      // Auto-serialise; mode/pdi scribbled during SHIFT must be ignored.
      d0 = n_done;
      start = 1'b1; pdi = 4'b1011;
      @(negedge clk);
      start = 1'b0; mode = 2'b11; pdi = 4'b0110;
      for (int k = 0; k < W; k++) begin
         bits[k] = sout_lsb; bz[k] = busy; dn[k] = done;
         @(negedge clk);
      end
      chk("auto_final_pdo", pdo, 4'b0000);
      chk("auto_busy_fell", W'(busy), '0);
      mode = 2'b00;
      chk("auto_serial_bits", bits, 4'b1011);
      chk("auto_busy_cycles", bz, 4'b1111);
      chk("auto_done_last", dn, 4'b1000);
      chk("auto_done_count", W'(n_done - d0), W'(1));

      d0 = n_done;
      start = 1'b1; pdi = 4'b1011;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #1 reset_n = 1'b0;
      #1;
      chk("abort_pdo", pdo, 4'b0000);
      chk("abort_busy", W'(busy), '0);
      chk("abort_done", W'(done), '0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_no_done", W'(n_done - d0), '0);

      start = 1'b1; pdi = 4'b0110;
      repeat (12) @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20 && busy; i++) @(negedge clk);
      chk("held_start_drains", W'(busy), '0);

      rot = 1'b1;
      start = 1'b1; pdi = 4'b1011;
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < W; k++) begin
         bits[k] = sout_lsb;
         @(negedge clk);
      end
      chk("rot_serial_bits", bits, 4'b1011);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      chk("rot_final_pdo", pdo, 4'b1011);
`else
      chk("rot_final_pdo", pdo, 4'b0000);
`endif

      rot = 1'b0; mode = 2'b11; pdi = 4'b0001;
      @(negedge clk);
      mode = 2'b01; rot = 1'b1; sin_msb = 1'b0;
      @(negedge clk);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
      chk("rot_manual_right", pdo, 4'b1000);
`else
      chk("rot_manual_right", pdo, 4'b0000);
`endif
      mode = 2'b00; rot = 1'b0;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
